// File: rtl/laser_game_pkg.sv
// Shared types and constants for the laser hit-detection game logic.
package laser_game_pkg;

  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned X_W        = 9;
  localparam int unsigned Y_W        = 8;
  localparam int unsigned COORD_IN_W = 17;
  // One bit wider than the incoming coordinate so window bounds never wrap
  localparam int unsigned CMP_W      = 18;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DWELL    = 3'd2,
    ST_HIT      = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_e;

  // Larger of two unsigned values, used when sizing the shared counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/laser_hit_detector_if.sv
// Game-side bus of the hit detector: marker/target in, hit status out.
interface laser_hit_detector_if
  import laser_game_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
) ();

  logic                  game_en;
  logic [COORD_IN_W-1:0] avg_x;
  logic [COORD_IN_W-1:0] avg_y;
  logic [X_W-1:0]        target_x;
  logic [Y_W-1:0]        target_y;
  logic                  in_target;
  logic                  hit;
  logic [SCORE_W-1:0]    score;
  logic [STATE_W-1:0]    state_o;

  // Game controller / stimulus side
  modport master (
    output game_en, avg_x, avg_y, target_x, target_y,
    input  in_target, hit, score, state_o
  );

  // Detector side
  modport slave (
    input  game_en, avg_x, avg_y, target_x, target_y,
    output in_target, hit, score, state_o
  );

endinterface

// File: rtl/target_window_cmp.sv
// Combinational marker-presence and inclusive target-window test.
module target_window_cmp
  import laser_game_pkg::*;
#(
  parameter int unsigned BOX_HALF = 16
) (
  input  logic [COORD_IN_W-1:0] x,
  input  logic [COORD_IN_W-1:0] y,
  input  logic [X_W-1:0]        tx,
  input  logic [Y_W-1:0]        ty,
  output logic                  present_c,
  output logic                  inside_c
);

  logic [CMP_W-1:0] x_e;
  logic [CMP_W-1:0] y_e;
  logic [CMP_W-1:0] tx_e;
  logic [CMP_W-1:0] ty_e;
  logic [CMP_W-1:0] half_e;

  // Widen everything so x+half and tx+half cannot overflow and no subtraction is needed
  always_comb begin
    x_e    = CMP_W'(x);
    y_e    = CMP_W'(y);
    tx_e   = CMP_W'(tx);
    ty_e   = CMP_W'(ty);
    half_e = CMP_W'(BOX_HALF);
  end

  // (0,0) means no marker; anything beyond the image is a bogus coordinate
  always_comb begin
    present_c = ((x != '0) || (y != '0)) &&
                (x <= COORD_IN_W'(IMG_W - 1)) &&
                (y <= COORD_IN_W'(IMG_H - 1));
  end

  // Inclusive box test on both axes
  always_comb begin
    inside_c = ((x_e + half_e) >= tx_e) && (x_e <= (tx_e + half_e)) &&
               ((y_e + half_e) >= ty_e) && (y_e <= (ty_e + half_e));
  end

endmodule

// File: rtl/laser_hit_detector.sv
// Dwell-based laser hit detector: window test pipeline, game FSM and score.
module laser_hit_detector
  import laser_game_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 25_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
  parameter int unsigned BOX_HALF        = 16,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  laser_hit_detector_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max_u(DWELL_CYCLES, COOLDOWN_CYCLES));

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);

  logic [COORD_IN_W-1:0] x_q;
  logic [COORD_IN_W-1:0] y_q;
  logic [X_W-1:0]        tx_q;
  logic [Y_W-1:0]        ty_q;
  logic                  present_c;
  logic                  inside_c;
  logic                  in_target_q;
  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [SCORE_W-1:0]    score_q;
  logic                  hit_q;

  // Stage 1: capture marker and target coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      x_q  <= bus.avg_x;
      y_q  <= bus.avg_y;
      tx_q <= bus.target_x;
      ty_q <= bus.target_y;
    end
  end

  target_window_cmp #(
    .BOX_HALF (BOX_HALF)
  ) u_cmp (
    .x         (x_q),
    .y         (y_q),
    .tx        (tx_q),
    .ty        (ty_q),
    .present_c (present_c),
    .inside_c  (inside_c)
  );

  // Stage 2: register the on-target decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_target_q <= 1'b0;
    end else begin
      in_target_q <= present_c & inside_c;
    end
  end

  // Game FSM with shared dwell/cooldown counter; hit is set alongside entry to HIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (!bus.game_en) begin
        // Disable wins over every transition; score is kept for display
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_ARMED;
            cnt     <= '0;
            score_q <= '0;
          end
          ST_ARMED: begin
            if (in_target_q) begin
              state <= ST_DWELL;
              cnt   <= CNT_W'(1);
            end
          end
          ST_DWELL: begin
            if (!in_target_q) begin
              // Any gap forfeits the whole dwell
              state <= ST_ARMED;
              cnt   <= '0;
            end else if (cnt == DWELL_LAST) begin
              state <= ST_HIT;
              cnt   <= '0;
              hit_q <= 1'b1;
              if (score_q != '1) begin
                score_q <= score_q + SCORE_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_HIT: begin
            state <= ST_COOLDOWN;
            cnt   <= '0;
          end
          ST_COOLDOWN: begin
            if (cnt == COOL_LAST) begin
              state <= ST_ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Drive the registered results onto the bus
  always_comb begin
    bus.in_target = in_target_q;
    bus.hit       = hit_q;
    bus.score     = score_q;
    bus.state_o   = STATE_W'(state);
  end

endmodule
